vr_wheel_gen: RTL

VR_WHEEL_GEN -- requirements
Module: vr_wheel_gen

---
 rtl/vr_wheel_if.sv | 26 ++
 rtl/vr_wheel_gen.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/vr_wheel_if.sv
// Wheel generator bus: run/config request from the controller, wheel
// signal and status back from the generator.
interface vr_wheel_if #(
   parameter int PW = 16,
   parameter int TW = 8
);
   logic          enable;
   logic [PW-1:0] tooth_period;
   logic [TW-1:0] teeth_total;
   logic [TW-1:0] teeth_missing;
   logic          vr_out;
   logic [TW-1:0] tooth_idx;
   logic          rev_pulse;
   logic          busy;
   logic          cfg_err;

   modport master (
      output enable, tooth_period, teeth_total, teeth_missing,
      input  vr_out, tooth_idx, rev_pulse, busy, cfg_err
   );

   modport slave (
      input  enable, tooth_period, teeth_total, teeth_missing,
      output vr_out, tooth_idx, rev_pulse, busy, cfg_err
   );
endinterface

// File: rtl/vr_wheel_gen.sv
// Missing-tooth crank wheel generator. Emits a square wave per present tooth
// (P>>1 cycles high, remainder low) followed by P low cycles per missing
// position. Period is latched per tooth position, tooth/missing counts per
// revolution; enable is only honoured at tooth boundaries.
module vr_wheel_gen #(
   parameter int PW = 16,
   parameter int TW = 8
) (
   input  logic       clk,
   input  logic       rst,
   vr_wheel_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} state_t;

   state_t        state, state_n;
   logic [PW-1:0] cnt, cnt_n;        // cycles elapsed in current phase, 1-based
   logic [PW-1:0] p_q, p_n;          // period latched for current tooth position
   logic [TW-1:0] tot_q, tot_n;
   logic [TW-1:0] mis_q, mis_n;
   logic [TW-1:0] idx_q, idx_n;
   logic          vr_q, vr_n;
   logic          rev_q, rev_n;
   logic          busy_q;
   logic          err_q, err_n;

   logic [PW-1:0] eff_p;
   logic [PW-1:0] h_len;
   logic [PW-1:0] l_len;
   logic          cfg_ok;
   logic          bnd;
   logic [TW-1:0] idx_inc;
   logic          last_pos;

   assign eff_p    = (bus.tooth_period < PW'(2)) ? PW'(2) : bus.tooth_period;
   assign cfg_ok   = (bus.teeth_total >= TW'(2)) && (bus.teeth_missing < bus.teeth_total);
   assign h_len    = p_q >> 1;
   assign l_len    = p_q - h_len;
   assign idx_inc  = idx_q + TW'(1);
   assign last_pos = (idx_q == tot_q - TW'(1));

   // Next-state, counters and next registered outputs
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      p_n     = p_q;
      tot_n   = tot_q;
      mis_n   = mis_q;
      idx_n   = idx_q;
      vr_n    = vr_q;
      rev_n   = 1'b0;
      err_n   = 1'b0;
      bnd     = 1'b0;

      case (state)
         IDLE: begin
            vr_n  = 1'b0;
            idx_n = '0;
            cnt_n = '0;
            if (bus.enable) begin
               tot_n = bus.teeth_total;
               mis_n = bus.teeth_missing;
               if (cfg_ok) begin
                  state_n = HIGH;
                  p_n     = eff_p;
                  cnt_n   = PW'(1);
                  vr_n    = 1'b1;
                  rev_n   = 1'b1;
               end else begin
                  err_n = 1'b1;
               end
            end
         end
         HIGH: begin
            if (cnt == h_len) begin
               state_n = LOW;
               cnt_n   = PW'(1);
               vr_n    = 1'b0;
            end else begin
               cnt_n = cnt + PW'(1);
            end
         end
         LOW: begin
            if (cnt == l_len) bnd = 1'b1;
            else              cnt_n = cnt + PW'(1);
         end
         GAP: begin
            if (cnt == p_q) bnd = 1'b1;
            else            cnt_n = cnt + PW'(1);
         end
         default: state_n = IDLE;
      endcase

      // Tooth boundary: sample enable, advance or wrap the position
      if (bnd) begin
         if (!bus.enable) begin
            state_n = IDLE;
            vr_n    = 1'b0;
            idx_n   = '0;
            cnt_n   = '0;
         end else if (last_pos) begin
            tot_n = bus.teeth_total;
            mis_n = bus.teeth_missing;
            idx_n = '0;
            if (cfg_ok) begin
               state_n = HIGH;
               p_n     = eff_p;
               cnt_n   = PW'(1);
               vr_n    = 1'b1;
               rev_n   = 1'b1;
            end else begin
               // New revolution config is bad: park and flag it
               state_n = IDLE;
               cnt_n   = '0;
               vr_n    = 1'b0;
               err_n   = 1'b1;
            end
         end else begin
            idx_n = idx_inc;
            p_n   = eff_p;
            cnt_n = PW'(1);
            if (idx_inc < tot_q - mis_q) begin
               state_n = HIGH;
               vr_n    = 1'b1;
            end else begin
               state_n = GAP;
               vr_n    = 1'b0;
            end
         end
      end
   end

   // State, counters and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         p_q    <= '0;
         tot_q  <= '0;
         mis_q  <= '0;
         idx_q  <= '0;
         vr_q   <= 1'b0;
         rev_q  <= 1'b0;
         busy_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         p_q    <= p_n;
         tot_q  <= tot_n;
         mis_q  <= mis_n;
         idx_q  <= idx_n;
         vr_q   <= vr_n;
         rev_q  <= rev_n;
         busy_q <= (state_n != IDLE);
         err_q  <= err_n;
      end
   end

   assign bus.vr_out    = vr_q;
   assign bus.tooth_idx = idx_q;
   assign bus.rev_pulse = rev_q;
   assign bus.busy      = busy_q;
   assign bus.cfg_err   = err_q;

endmodule
